// File: rtl/serial_paralelo_pkg.sv
// Shared types and constants for the serial-to-parallel receiver alignment logic.
package serial_paralelo_pkg;

    typedef enum logic [1:0] {
        StHunt     = 2'd0,
        StCheck    = 2'd1,
        StSlipWait = 2'd2,
        StLocked   = 2'd3
    } sync_state_e;

    localparam logic [7:0] COMMA_BC = 8'hBC;

endpackage

// File: rtl/sync_ctrl_strobe_counter.sv
// Saturating strobe counter with clear, enable and terminal-count flag.
// tc is high when the next enabled increment will bring the count to LIMIT.
module sync_ctrl_strobe_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LIMIT = 1
) (
    input  logic clk_4f,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // clr together with en restarts the count at one.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = en ? WIDTH'(1) : '0;
        end else if (en && (cnt_q != WIDTH'(LIMIT))) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/serial_paralelo_sync_ctrl.sv
// Comma hunt, bit-slip and lock controller for the deserializer byte stream.
// Forwards non-comma bytes while locked; drops lock on gap timeout or realign.
module serial_paralelo_sync_ctrl
    import serial_paralelo_pkg::*;
#(
    parameter logic [7:0]  COMMA       = COMMA_BC,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned SLIP_WINDOW = 16,
    parameter int unsigned SLIP_SETTLE = 2,
    parameter int unsigned MAX_GAP     = 64
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_strobe,
    input  logic       realign,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       bit_slip,
    output logic       sync_lost
);

    localparam int unsigned MAX_AB  = (SLIP_WINDOW > LOCK_COUNT) ? SLIP_WINDOW : LOCK_COUNT;
    localparam int unsigned MAX_CD  = (MAX_GAP > SLIP_SETTLE) ? MAX_GAP : SLIP_SETTLE;
    localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    // A disabled watchdog still needs a legal counter limit.
    localparam int unsigned GAP_LIM = (MAX_GAP == 0) ? 1 : MAX_GAP;

    sync_state_e state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        active_q, active_d;
    logic        slip_q, slip_d;
    logic        lost_q, lost_d;

    logic clr_all;
    logic miss_clr, miss_en, miss_tc;
    logic comma_clr, comma_en, comma_tc;
    logic settle_clr, settle_en, settle_tc;
    logic gap_clr, gap_en, gap_tc;
    logic is_comma;

    assign is_comma = (byte_in == COMMA);

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        slip_d     = 1'b0;
        lost_d     = 1'b0;
        clr_all    = 1'b0;
        miss_clr   = 1'b0;
        miss_en    = 1'b0;
        comma_clr  = 1'b0;
        comma_en   = 1'b0;
        settle_en  = 1'b0;
        gap_clr    = 1'b0;
        gap_en     = 1'b0;

        if (realign) begin
            state_d = StHunt;
            clr_all = 1'b1;
            lost_d  = (state_q == StLocked);
        end else if (byte_strobe) begin
            unique case (state_q)
                StHunt: begin
                    if (is_comma) begin
                        miss_clr  = 1'b1;
                        comma_clr = 1'b1;
                        comma_en  = 1'b1;
                        state_d   = (LOCK_COUNT == 1) ? StLocked : StCheck;
                    end else if (miss_tc) begin
                        slip_d   = 1'b1;
                        miss_clr = 1'b1;
                        state_d  = StSlipWait;
                    end else begin
                        miss_en = 1'b1;
                    end
                end
                StSlipWait: begin
                    if (settle_tc) begin
                        clr_all = 1'b1;
                        state_d = StHunt;
                    end else begin
                        settle_en = 1'b1;
                    end
                end
                StCheck: begin
                    if (!is_comma) begin
                        clr_all = 1'b1;
                        state_d = StHunt;
                    end else if (comma_tc) begin
                        clr_all = 1'b1;
                        state_d = StLocked;
                    end else begin
                        comma_en = 1'b1;
                    end
                end
                StLocked: begin
                    if (is_comma) begin
                        gap_clr = 1'b1;
                    end else begin
                        data_d  = byte_in;
                        valid_d = 1'b1;
                        if ((MAX_GAP != 0) && gap_tc) begin
                            clr_all = 1'b1;
                            lost_d  = 1'b1;
                            state_d = StHunt;
                        end else begin
                            gap_en = 1'b1;
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
        end

        active_d = (state_d == StLocked);
    end

    assign settle_clr = clr_all;

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            state_q  <= StHunt;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
            slip_q   <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            active_q <= active_d;
            slip_q   <= slip_d;
            lost_q   <= lost_d;
        end
    end

    sync_ctrl_strobe_counter #(.WIDTH(CNT_W), .LIMIT(SLIP_WINDOW)) u_miss_cnt (
        .clk_4f (clk_4f),
        .reset  (reset),
        .clr    (clr_all | miss_clr),
        .en     (miss_en),
        .tc     (miss_tc)
    );

    sync_ctrl_strobe_counter #(.WIDTH(CNT_W), .LIMIT(LOCK_COUNT)) u_comma_cnt (
        .clk_4f (clk_4f),
        .reset  (reset),
        .clr    (clr_all | comma_clr),
        .en     (comma_en),
        .tc     (comma_tc)
    );

    sync_ctrl_strobe_counter #(.WIDTH(CNT_W), .LIMIT(SLIP_SETTLE)) u_settle_cnt (
        .clk_4f (clk_4f),
        .reset  (reset),
        .clr    (settle_clr),
        .en     (settle_en),
        .tc     (settle_tc)
    );

    sync_ctrl_strobe_counter #(.WIDTH(CNT_W), .LIMIT(GAP_LIM)) u_gap_cnt (
        .clk_4f (clk_4f),
        .reset  (reset),
        .clr    (clr_all | gap_clr),
        .en     (gap_en),
        .tc     (gap_tc)
    );

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = active_q;
    assign bit_slip  = slip_q;
    assign sync_lost = lost_q;

endmodule
